// File: rtl/hs32_mem_arb_pkg.sv
// Shared types for the hs32 memory-port arbiter: FSM states, owner encoding, debug view.
// The optional round-robin policy is selected with HS32_MEM_ARB_RR_EN.
package hs32_mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_MEM  = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_EXEC  = 1'b1
    } arb_owner_e;

    // Wide enough for STARVE_MAX up to 15.
    localparam int STARVE_W = 4;

    typedef struct packed {
        arb_state_e state;
        arb_owner_e owner;
    } arb_dbg_t;

    function automatic arb_owner_e other_owner(input arb_owner_e own);
        return (own == OWN_FETCH) ? OWN_EXEC : OWN_FETCH;
    endfunction

endpackage

// File: rtl/hs32_mem_arb_if.sv
// Bus bundle between fetch/execute requesters, the arbiter and the memory port.
// Handshake: req* is a level held until the matching 1-cycle ack*; reqm is held until the 1-cycle ackm.
interface hs32_mem_arb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();

    logic [ADDR_W-1:0] addrf;
    logic              reqf;
    logic              ackf;
    logic [DATA_W-1:0] dtrf;

    logic [ADDR_W-1:0] addre;
    logic [DATA_W-1:0] dtwe;
    logic              rwe;
    logic              reqe;
    logic              acke;
    logic [DATA_W-1:0] dtre;

    logic [ADDR_W-1:0] addrm;
    logic [DATA_W-1:0] dtwm;
    logic              rwm;
    logic              reqm;
    logic              ackm;
    logic [DATA_W-1:0] dtrm;

    // Arbiter view.
    modport slave (
        input  addrf, reqf, addre, dtwe, rwe, reqe, ackm, dtrm,
        output ackf, dtrf, acke, dtre, addrm, dtwm, rwm, reqm
    );

    // Requester/memory environment view.
    modport master (
        output addrf, reqf, addre, dtwe, rwe, reqe, ackm, dtrm,
        input  ackf, dtrf, acke, dtre, addrm, dtwm, rwm, reqm
    );

endinterface

// File: rtl/hs32_mem_arb_pick.sv
// Combinational winner select between fetch and execute requests.
// HS32_MEM_ARB_RR_EN selects round-robin; otherwise execute priority with starvation relief.
module hs32_mem_arb_pick
    import hs32_mem_arb_pkg::*;
`ifndef HS32_MEM_ARB_RR_EN
#(
    parameter int STARVE_MAX = 4
)
`endif
(
    input  logic                reqf,
    input  logic                reqe,
`ifdef HS32_MEM_ARB_RR_EN
    input  arb_owner_e          last_own,
`else
    input  logic [STARVE_W-1:0] starve,
`endif
    output logic                grant,
    output arb_owner_e          owner
);

    always_comb begin
        grant = reqf | reqe;
        owner = OWN_EXEC;
        if (reqf && !reqe) begin
            owner = OWN_FETCH;
        end else if (reqf && reqe) begin
`ifdef HS32_MEM_ARB_RR_EN
            owner = other_owner(last_own);
`else
            // Fetch only wins contention once execute has taken STARVE_MAX grants in a row.
            owner = (starve >= STARVE_W'(STARVE_MAX)) ? OWN_FETCH : OWN_EXEC;
`endif
        end
    end

endmodule

// File: rtl/hs32_mem_arb.sv
// Single-port memory arbiter for hs32 fetch and execute; one transaction in flight.
// Define HS32_MEM_ARB_RR_EN for round-robin arbitration instead of execute priority.
module hs32_mem_arb
    import hs32_mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    hs32_mem_arb_if.slave        bus,
    output logic                 busy,
    output arb_dbg_t             dbg
);

    arb_state_e        state_q, state_d;
    arb_owner_e        owner_q, owner_d;
    logic [ADDR_W-1:0] addrm_q, addrm_d;
    logic [DATA_W-1:0] dtwm_q, dtwm_d;
    logic              rwm_q, rwm_d;
    logic              reqm_q, reqm_d;
    logic              ackf_q, ackf_d;
    logic              acke_q, acke_d;
    logic [DATA_W-1:0] dtrf_q, dtrf_d;
    logic [DATA_W-1:0] dtre_q, dtre_d;

    logic              pick_grant;
    arb_owner_e        pick_owner;

`ifdef HS32_MEM_ARB_RR_EN
    arb_owner_e        ptr_q, ptr_d;

    hs32_mem_arb_pick u_pick (
        .reqf     (bus.reqf),
        .reqe     (bus.reqe),
        .last_own (ptr_q),
        .grant    (pick_grant),
        .owner    (pick_owner)
    );
`else
    logic [STARVE_W-1:0] starve_q, starve_d;

    hs32_mem_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .reqf   (bus.reqf),
        .reqe   (bus.reqe),
        .starve (starve_q),
        .grant  (pick_grant),
        .owner  (pick_owner)
    );
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addrm_d = addrm_q;
        dtwm_d  = dtwm_q;
        rwm_d   = rwm_q;
        reqm_d  = reqm_q;
        ackf_d  = 1'b0;
        acke_d  = 1'b0;
        dtrf_d  = dtrf_q;
        dtre_d  = dtre_q;
`ifdef HS32_MEM_ARB_RR_EN
        ptr_d   = ptr_q;
`else
        starve_d = starve_q;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (pick_grant) begin
                    state_d = ARB_MEM;
                    owner_d = pick_owner;
                    reqm_d  = 1'b1;
                    if (pick_owner == OWN_FETCH) begin
                        addrm_d = bus.addrf;
                        dtwm_d  = '0;
                        rwm_d   = 1'b0;
                    end else begin
                        addrm_d = bus.addre;
                        dtwm_d  = bus.dtwe;
                        rwm_d   = bus.rwe;
                    end
`ifdef HS32_MEM_ARB_RR_EN
                    ptr_d = pick_owner;
`else
                    // Count only execute wins that actually held fetch off.
                    if (pick_owner == OWN_FETCH) begin
                        starve_d = '0;
                    end else if (bus.reqf) begin
                        starve_d = starve_q + STARVE_W'(1);
                    end
`endif
                end
            end
            ARB_MEM: begin
                if (bus.ackm) begin
                    state_d = ARB_RESP;
                    reqm_d  = 1'b0;
                    if (owner_q == OWN_FETCH) begin
                        dtrf_d = bus.dtrm;
                        ackf_d = 1'b1;
                    end else begin
                        dtre_d = bus.dtrm;
                        acke_d = 1'b1;
                    end
                end
            end
            ARB_RESP: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            owner_q <= OWN_FETCH;
            addrm_q <= '0;
            dtwm_q  <= '0;
            rwm_q   <= 1'b0;
            reqm_q  <= 1'b0;
            ackf_q  <= 1'b0;
            acke_q  <= 1'b0;
            dtrf_q  <= '0;
            dtre_q  <= '0;
`ifdef HS32_MEM_ARB_RR_EN
            ptr_q   <= OWN_FETCH;
`else
            starve_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addrm_q <= addrm_d;
            dtwm_q  <= dtwm_d;
            rwm_q   <= rwm_d;
            reqm_q  <= reqm_d;
            ackf_q  <= ackf_d;
            acke_q  <= acke_d;
            dtrf_q  <= dtrf_d;
            dtre_q  <= dtre_d;
`ifdef HS32_MEM_ARB_RR_EN
            ptr_q   <= ptr_d;
`else
            starve_q <= starve_d;
`endif
        end
    end

    assign bus.addrm = addrm_q;
    assign bus.dtwm  = dtwm_q;
    assign bus.rwm   = rwm_q;
    assign bus.reqm  = reqm_q;
    assign bus.ackf  = ackf_q;
    assign bus.acke  = acke_q;
    assign bus.dtrf  = dtrf_q;
    assign bus.dtre  = dtre_q;

    assign busy      = (state_q != ARB_IDLE);
    assign dbg.state = state_q;
    assign dbg.owner = owner_q;

endmodule

// File: tb/tb_hs32_mem_arb.sv
// Self-checking bench for hs32_mem_arb: directed scenarios plus a randomized request mix.
// Expected grants come from a policy model; expectations queue in exp_q until the DUT grants.
module tb_hs32_mem_arb;
    import hs32_mem_arb_pkg::*;

    localparam int STARVE_MAX = 4;

    logic     clk;
    logic     reset;
    logic     busy;
    arb_dbg_t dbg;

    hs32_mem_arb_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    hs32_mem_arb #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy),
        .dbg   (dbg)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    int n_vec = 0;
    int n_err = 0;

    // {owner, rw, dtw[31:0], addr[31:0]}
    logic [65:0] exp_q[$];

    // Policy model state
    int   m_starve;
    logic m_last;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        bus.reqf  = 1'b0;
        bus.reqe  = 1'b0;
        bus.ackm  = 1'b0;
        bus.dtrm  = '0;
        bus.addrf = '0;
        bus.addre = '0;
        bus.dtwe  = '0;
        bus.rwe   = 1'b0;
        repeat (3) tick();
        reset     = 1'b0;
        m_starve  = 0;
        m_last    = 1'b0;
        exp_q.delete();
    endtask

    // Driver: compute expected winner for the current request inputs and queue its bus request.
    task automatic expect_grant();
        logic own;
        if (bus.reqf && !bus.reqe) own = 1'b0;
        else if (bus.reqe && !bus.reqf) own = 1'b1;
        else begin
`ifdef HS32_MEM_ARB_RR_EN
            own = ~m_last;
`else
            own = (m_starve == STARVE_MAX) ? 1'b0 : 1'b1;
`endif
        end
`ifdef HS32_MEM_ARB_RR_EN
        m_last = own;
`else
        if (!own) m_starve = 0;
        else if (bus.reqf) m_starve = m_starve + 1;
`endif
        if (own) exp_q.push_back({1'b1, bus.rwe, bus.dtwe, bus.addre});
        else     exp_q.push_back({1'b0, 1'b0, 32'h0, bus.addrf});
    endtask

    // Memory responder + scoreboard pop: waits for the grant, holds ackm off for 'delay'
    // MEM cycles, then answers with rdata and checks the response back to the owner.
    task automatic run_txn(input int delay, input logic [31:0] rdata, input bit drop, input bit perturb);
        logic [65:0] exp;
        logic        own;
        logic [31:0] other_dtr;
        int          waited;
        waited = 0;
        while (bus.reqm !== 1'b1 && waited < 10) begin
            tick();
            waited++;
        end
        n_vec++;
        if (bus.reqm !== 1'b1) begin
            $display("FAIL grant_timeout: reqm=%b required 1", bus.reqm);
            n_err++;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            return;
        end
        exp = exp_q.pop_front();
        own = exp[65];
        n_vec++;
        if ({bus.rwm, bus.dtwm, bus.addrm} !== exp[64:0]) begin
            $display("FAIL mem_req: got rw=%b dtw=%h addr=%h required rw=%b dtw=%h addr=%h (owner %0d)",
                     bus.rwm, bus.dtwm, bus.addrm, exp[64], exp[63:32], exp[31:0], own);
            n_err++;
        end
        other_dtr = own ? bus.dtrf : bus.dtre;
        if (perturb) begin
            bus.addrf = 32'h200;
            bus.addre = bus.addre + 32'h4;
            bus.dtwe  = ~bus.dtwe;
        end
        repeat (delay) begin
            tick();
            n_vec++;
            if ({bus.reqm, bus.ackf, bus.acke, bus.rwm, bus.dtwm, bus.addrm} !== {3'b100, exp[64:0]}) begin
                $display("FAIL mem_hold: got req=%b ackf=%b acke=%b rw=%b dtw=%h addr=%h required 1 0 0 %b %h %h",
                         bus.reqm, bus.ackf, bus.acke, bus.rwm, bus.dtwm, bus.addrm,
                         exp[64], exp[63:32], exp[31:0]);
                n_err++;
            end
        end
        bus.ackm = 1'b1;
        bus.dtrm = rdata;
        tick();
        bus.ackm = 1'b0;
        bus.dtrm = $urandom;
        n_vec++;
        if ({bus.ackf, bus.acke} !== (own ? 2'b01 : 2'b10)) begin
            $display("FAIL ack_sel: got ackf=%b acke=%b required owner %0d acked", bus.ackf, bus.acke, own);
            n_err++;
        end
        n_vec++;
        if ((own ? bus.dtre : bus.dtrf) !== rdata) begin
            $display("FAIL rdata: got %h required %h", (own ? bus.dtre : bus.dtrf), rdata);
            n_err++;
        end
        n_vec++;
        if ((own ? bus.dtrf : bus.dtre) !== other_dtr) begin
            $display("FAIL dtr_hold: got %h required %h", (own ? bus.dtrf : bus.dtre), other_dtr);
            n_err++;
        end
        n_vec++;
        if (bus.reqm !== 1'b0 || busy !== 1'b1 || dbg.state !== ARB_RESP) begin
            $display("FAIL resp_state: reqm=%b busy=%b state=%0d required 0 1 %0d",
                     bus.reqm, busy, dbg.state, ARB_RESP);
            n_err++;
        end
        if (drop) begin
            if (own) bus.reqe = 1'b0;
            else     bus.reqf = 1'b0;
        end
        tick();
        n_vec++;
        if ({bus.ackf, bus.acke, bus.reqm, busy} !== 4'b0000) begin
            $display("FAIL idle_state: ackf=%b acke=%b reqm=%b busy=%b required 0 0 0 0",
                     bus.ackf, bus.acke, bus.reqm, busy);
            n_err++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if ({bus.ackf, bus.acke, bus.reqm, bus.rwm, busy} !== 5'b0) begin
            $display("FAIL reset_ctl: ackf=%b acke=%b reqm=%b rwm=%b busy=%b required all 0",
                     bus.ackf, bus.acke, bus.reqm, bus.rwm, busy);
            n_err++;
        end
        n_vec++;
        if ({bus.addrm, bus.dtwm, bus.dtrf, bus.dtre} !== 128'h0) begin
            $display("FAIL reset_data: addrm=%h dtwm=%h dtrf=%h dtre=%h required 0",
                     bus.addrm, bus.dtwm, bus.dtrf, bus.dtre);
            n_err++;
        end
        n_vec++;
        if (dbg.state !== ARB_IDLE) begin
            $display("FAIL reset_state: state=%0d required %0d", dbg.state, ARB_IDLE);
            n_err++;
        end
    endtask

    task automatic test_fetch_only();
        bus.addrf = 32'h100;
        bus.reqf  = 1'b1;
        expect_grant();
        tick();
        n_vec++;
        if (bus.reqm !== 1'b1 || busy !== 1'b1) begin
            $display("FAIL fetch_latency: reqm=%b busy=%b required 1 1", bus.reqm, busy);
            n_err++;
        end
        run_txn(2, 32'hDEADBEEF, 1'b1, 1'b0);
    endtask

    task automatic test_store_only();
        bus.addre = 32'h2000;
        bus.dtwe  = 32'h12345678;
        bus.rwe   = 1'b1;
        bus.reqe  = 1'b1;
        expect_grant();
        run_txn(5, 32'h0BAD_F00D, 1'b1, 1'b0);
        n_vec++;
        if (bus.dtrf !== 32'hDEADBEEF) begin
            $display("FAIL fetch_data_kept: dtrf=%h required deadbeef", bus.dtrf);
            n_err++;
        end
        bus.rwe   = 1'b0;
        bus.addre = 32'h3000;
        bus.reqe  = 1'b1;
        expect_grant();
        run_txn(0, 32'hA5A5_0001, 1'b1, 1'b0);
    endtask

    task automatic test_addr_change();
        bus.addrf = 32'h100;
        bus.addre = 32'h4000;
        bus.reqf  = 1'b1;
        expect_grant();
        run_txn(3, 32'h1111_2222, 1'b1, 1'b1);
    endtask

    task automatic test_back_to_back();
        bus.addre = 32'h40;
        bus.rwe   = 1'b0;
        bus.reqe  = 1'b1;
        expect_grant();
        run_txn(1, 32'hC0DE_0001, 1'b0, 1'b0);
        bus.addre = 32'h44;
        expect_grant();
        tick();
        n_vec++;
        if (bus.reqm !== 1'b1 || bus.addrm !== 32'h44) begin
            $display("FAIL b2b_regrant: reqm=%b addrm=%h required 1 00000044", bus.reqm, bus.addrm);
            n_err++;
        end
        run_txn(0, 32'hC0DE_0002, 1'b1, 1'b0);
    endtask

    task automatic test_contention();
        do_reset();
        bus.addrf = 32'h1000;
        bus.addre = 32'h5000;
        bus.dtwe  = 32'h7777_0000;
        bus.rwe   = 1'b1;
        bus.reqf  = 1'b1;
        bus.reqe  = 1'b1;
        for (int i = 0; i < 12; i++) begin
            expect_grant();
            run_txn($urandom_range(0, 3), $urandom, 1'b0, 1'b0);
            bus.addrf = bus.addrf + 32'h4;
            bus.addre = bus.addre + 32'h4;
            bus.dtwe  = bus.dtwe + 32'h1;
        end
        bus.reqf = 1'b0;
        bus.reqe = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        bus.addrf = 32'h700;
        bus.reqf  = 1'b1;
        tick();
        n_vec++;
        if (bus.reqm !== 1'b1 || bus.addrm !== 32'h700) begin
            $display("FAIL abort_grant: reqm=%b addrm=%h required 1 00000700", bus.reqm, bus.addrm);
            n_err++;
        end
        tick();
        reset    = 1'b1;
        bus.reqf = 1'b0;
        bus.ackm = 1'b1;
        bus.dtrm = 32'hFFFF_0000;
        tick();
        reset    = 1'b0;
        bus.ackm = 1'b0;
        m_starve = 0;
        m_last   = 1'b0;
        n_vec++;
        if ({bus.reqm, busy, bus.ackf, bus.acke} !== 4'b0000) begin
            $display("FAIL abort_state: reqm=%b busy=%b ackf=%b acke=%b required 0 0 0 0",
                     bus.reqm, busy, bus.ackf, bus.acke);
            n_err++;
        end
        tick();
        n_vec++;
        if ({bus.reqm, busy, bus.ackf, bus.acke} !== 4'b0000) begin
            $display("FAIL abort_after: reqm=%b busy=%b ackf=%b acke=%b required 0 0 0 0",
                     bus.reqm, busy, bus.ackf, bus.acke);
            n_err++;
        end
        bus.ackm = 1'b1;
        bus.dtrm = 32'h5555_5555;
        tick();
        bus.ackm = 1'b0;
        repeat (2) begin
            tick();
            n_vec++;
            if ({bus.ackf, bus.acke, busy} !== 3'b000 || bus.dtrf !== 32'h0 || bus.dtre !== 32'h0) begin
                $display("FAIL spurious_ackm: ackf=%b acke=%b busy=%b dtrf=%h dtre=%h required 0 0 0 0 0",
                         bus.ackf, bus.acke, busy, bus.dtrf, bus.dtre);
                n_err++;
            end
        end
    endtask

    task automatic test_random();
        logic f;
        logic e;
        for (int i = 0; i < 25; i++) begin
            f = 1'($urandom_range(0, 1));
            e = 1'($urandom_range(0, 1));
            if (!f && !e) e = 1'b1;
            bus.addrf = $urandom;
            bus.addre = $urandom;
            bus.dtwe  = $urandom;
            bus.rwe   = 1'($urandom_range(0, 1));
            bus.reqf  = f;
            bus.reqe  = e;
            expect_grant();
            run_txn($urandom_range(0, 4), $urandom, 1'b1, 1'b0);
        end
        bus.reqf = 1'b0;
        bus.reqe = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_fetch_only();
        test_store_only();
        test_addr_change();
        test_back_to_back();
        test_contention();
        test_reset_mid();
        test_random();
        n_vec++;
        if (exp_q.size() != 0) begin
            $display("FAIL scoreboard_drain: %0d entries left required 0", exp_q.size());
            n_err++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
